background_arbiter: RTL

Sole owner of the single-port 256x256x12 background tile RAM (4x4-pixel tiles, 4:4:4 RGB). Shares the RAM between three requesters: the VGA pixel read path (absolute priority during active video), single-tile writes from game logic (req/ack handshake) and a built-in rectangle-fill sequencer. Writes happen only during blanking.

---
 rtl/background_arbiter_if.sv | 46 ++++
 rtl/background_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/background_arbiter_if.sv
// Bus bundle around the background tile RAM arbiter: display read path,
// single-tile write handshake, rectangle-fill control and the RAM port.
interface background_arbiter_if;
    logic [9:0]  disp_x;
    logic [9:0]  disp_y;
    logic        disp_active;
    logic [11:0] disp_q;

    logic        wr_req;
    logic [7:0]  wr_tile_x;
    logic [7:0]  wr_tile_y;
    logic [11:0] wr_color;
    logic        wr_ack;

    logic        fill_start;
    logic [7:0]  fill_x0;
    logic [7:0]  fill_y0;
    logic [7:0]  fill_x1;
    logic [7:0]  fill_y1;
    logic [11:0] fill_color;
    logic        fill_busy;
    logic        fill_done;

    logic [15:0] ram_address;
    logic [11:0] ram_data;
    logic        ram_wren;
    logic [11:0] ram_q;

    modport master (
        output disp_x, disp_y, disp_active,
        output wr_req, wr_tile_x, wr_tile_y, wr_color,
        output fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
        output ram_q,
        input  disp_q, wr_ack, fill_busy, fill_done,
        input  ram_address, ram_data, ram_wren
    );

    modport slave (
        input  disp_x, disp_y, disp_active,
        input  wr_req, wr_tile_x, wr_tile_y, wr_color,
        input  fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
        input  ram_q,
        output disp_q, wr_ack, fill_busy, fill_done,
        output ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/background_arbiter.sv
// Owns the 256x256x12 background tile RAM; fixed priority per cycle:
// display read > single-tile write > rectangle-fill step.
module background_arbiter #(
    parameter int unsigned FILL_EN = 1
) (
    input logic                  clock,
    input logic                  resetn,
    background_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

    fill_state_t state;
    logic [7:0]  xlo, xhi, ylo, yhi;
    logic [7:0]  cur_x, cur_y;
    logic [11:0] color;
    logic [1:0]  disp_vld;

    logic        grant_wr, grant_fill, fill_last;
    logic [7:0]  nx_lo, nx_hi, ny_lo, ny_hi;
    logic        unused_bits;

    // Pixel-within-tile bits do not address the RAM.
    assign unused_bits = ^{bus.disp_x[1:0], bus.disp_y[1:0]};

    always_comb begin
        // wr_ack high blocks a re-grant so a late-dropped wr_req never writes twice.
        grant_wr   = !bus.disp_active && bus.wr_req && !bus.wr_ack;
        grant_fill = !bus.disp_active && !grant_wr && (state == FILL);
        fill_last  = (cur_x == xhi) && (cur_y == yhi);
        nx_lo      = (bus.fill_x0 < bus.fill_x1) ? bus.fill_x0 : bus.fill_x1;
        nx_hi      = (bus.fill_x0 < bus.fill_x1) ? bus.fill_x1 : bus.fill_x0;
        ny_lo      = (bus.fill_y0 < bus.fill_y1) ? bus.fill_y0 : bus.fill_y1;
        ny_hi      = (bus.fill_y0 < bus.fill_y1) ? bus.fill_y1 : bus.fill_y0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.ram_address <= '0;
            bus.ram_data    <= '0;
            bus.ram_wren    <= 1'b0;
            bus.disp_q      <= '0;
            bus.wr_ack      <= 1'b0;
            disp_vld        <= '0;
        end else begin
            disp_vld   <= {disp_vld[0], bus.disp_active};
            bus.disp_q <= disp_vld[1] ? bus.ram_q : '0;
            bus.wr_ack <= grant_wr;
            if (bus.disp_active) begin
                bus.ram_address <= {bus.disp_y[9:2], bus.disp_x[9:2]};
                bus.ram_wren    <= 1'b0;
            end else if (grant_wr) begin
                bus.ram_address <= {bus.wr_tile_y, bus.wr_tile_x};
                bus.ram_data    <= bus.wr_color;
                bus.ram_wren    <= 1'b1;
            end else if (grant_fill) begin
                bus.ram_address <= {cur_y, cur_x};
                bus.ram_data    <= color;
                bus.ram_wren    <= 1'b1;
            end else begin
                bus.ram_wren    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            bus.fill_busy <= 1'b0;
            bus.fill_done <= 1'b0;
            xlo           <= '0;
            xhi           <= '0;
            ylo           <= '0;
            yhi           <= '0;
            cur_x         <= '0;
            cur_y         <= '0;
            color         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.fill_done <= 1'b0;
                    if (bus.fill_start && (FILL_EN != 0)) begin
                        xlo           <= nx_lo;
                        xhi           <= nx_hi;
                        ylo           <= ny_lo;
                        yhi           <= ny_hi;
                        cur_x         <= nx_lo;
                        cur_y         <= ny_lo;
                        color         <= bus.fill_color;
                        bus.fill_busy <= 1'b1;
                        state         <= FILL;
                    end
                end
                FILL: begin
                    // Cursor only moves on a granted step, so pauses never skip tiles.
                    if (grant_fill) begin
                        if (fill_last) begin
                            bus.fill_done <= 1'b1;
                            state         <= DONE;
                        end else if (cur_x == xhi) begin
                            cur_x <= xlo;
                            cur_y <= cur_y + 8'd1;
                        end else begin
                            cur_x <= cur_x + 8'd1;
                        end
                    end
                end
                DONE: begin
                    bus.fill_done <= 1'b0;
                    bus.fill_busy <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
